// File: rtl/obf_pkg.sv
// -----------------------------------------------------------------------------
// obf_pkg
// Shared definitions for the obfuscated-cell key loader.
//   - Cell-mode codes, each written as {D_even, D_odd} for one camouflaged cell.
//   - Loader FSM state encoding.
//   - key_w(): key width in bits for a given number of cells.
// -----------------------------------------------------------------------------
package obf_pkg;

  // Per-cell select codes {D_even, D_odd}. The loader itself never decodes
  // these; they document what the downstream netlist does with each pair.
  localparam logic [1:0] CELL_PASS = 2'b00;
  localparam logic [1:0] CELL_INV  = 2'b01;
  localparam logic [1:0] CELL_C1   = 2'b10;
  localparam logic [1:0] CELL_C0   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  // Two select bits per obfuscated cell.
  function automatic int key_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// -----------------------------------------------------------------------------
// obf_key_shreg
// Shadow shift register for the serial key plus a running parity of every bit
// shifted in since the last clear. Bits enter at the MSB and move toward bit 0,
// so after KEY_W shifts the first received bit sits at data_o[0].
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   clr_i      clear data and parity (has priority over shift_i)
//   shift_i    shift bit_i in this cycle
//   bit_i      serial data bit
//   data_o     shadow contents
//   par_o      XOR of all bits shifted in since the last clear (== ^data_o)
// -----------------------------------------------------------------------------
module obf_key_shreg #(
  parameter int KEY_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] data_o,
  output logic             par_o
);

  logic [KEY_W-1:0] data_q;
  logic             par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else if (clr_i) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else if (shift_i) begin
      data_q <= {bit_i, data_q[KEY_W-1:1]};
      par_q  <= par_q ^ bit_i;
    end
  end

  assign data_o = data_q;
  assign par_o  = par_q;

endmodule

// File: rtl/obf_key_loader.sv
// -----------------------------------------------------------------------------
// obf_key_loader
// Serial key-programming engine for obfuscated gate cells. A frame is
// load_start, KEY_W key bits (D_0 first), then one even-parity bit. A clean
// frame is committed atomically to key_out; a bad one sets the sticky load_err.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   load_start      pulse: begin a frame (IDLE) or abort and restart (SHIFT)
//   key_bit         serial key / parity bit
//   key_bit_valid   key_bit is valid this cycle
//   key_bit_ready   loader can accept key_bit this cycle (high only in SHIFT)
//   key_out         committed select bits, key_out[2i+1:2i] = cell i
//   key_valid       a parity-clean key was committed since reset
//   busy            frame in progress (state != IDLE)
//   load_err        sticky error: bad parity or load attempted while locked
//   dbg_state_o     current FSM state
//
// Handshake: a bit transfers on a rising edge where key_bit_valid and
// key_bit_ready are both high. key_bit_ready is registered and does not depend
// on key_bit_valid; the source may hold valid low for any number of cycles.
// A bit presented in the same cycle as load_start is dropped.
// -----------------------------------------------------------------------------
module obf_key_loader
  import obf_pkg::*;
#(
  parameter int                   N_CELLS         = 5,
  parameter logic [2*N_CELLS-1:0] RESET_KEY       = '0,
  parameter bit                   LOCK_AFTER_LOAD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 key_bit,
  input  logic                 key_bit_valid,
  output logic                 key_bit_ready,
  output logic [2*N_CELLS-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 load_err,
  output state_e               dbg_state_o
);

  localparam int KEY_W = key_w(N_CELLS);
  localparam int CNT_W = $clog2(KEY_W + 1);
  // Count value at which the next transfer is the parity bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             par_q;
  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             busy_q;
  logic             ready_q;
  logic             err_q;

  logic [KEY_W-1:0] sh_data;
  logic             sh_par;
  logic             locked;
  logic             xfer;
  logic             start_ok;
  logic             abort;
  logic             sh_clr;
  logic             sh_en;
  logic             par_ok;

  assign locked   = LOCK_AFTER_LOAD && key_valid_q;
  // ready_q is only ever high in SHIFT, so xfer implies SHIFT.
  assign xfer     = key_bit_valid & ready_q;
  assign start_ok = (state_q == IDLE) & load_start & ~locked;
  assign abort    = (state_q == SHIFT) & load_start;
  assign sh_clr   = start_ok | abort;
  assign sh_en    = xfer & ~load_start & (cnt_q != CNT_LAST);
  // Even parity over key plus parity bit.
  assign par_ok   = ~(sh_par ^ par_q);

  obf_key_shreg #(
    .KEY_W (KEY_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sh_clr),
    .shift_i (sh_en),
    .bit_i   (key_bit),
    .data_o  (sh_data),
    .par_o   (sh_par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      key_q       <= RESET_KEY;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_start) begin
            if (locked) begin
              err_q <= 1'b1;
            end else begin
              state_q <= SHIFT;
              cnt_q   <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (load_start) begin
            cnt_q <= '0;
          end else if (xfer) begin
            if (cnt_q != CNT_LAST) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              par_q   <= key_bit;
              state_q <= CHECK;
              ready_q <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (par_ok) begin
            state_q <= COMMIT;
          end else begin
            err_q   <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        COMMIT: begin
          key_q       <= sh_data;
          key_valid_q <= 1'b1;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign key_bit_ready = ready_q;
  assign key_out       = key_q;
  assign key_valid     = key_valid_q;
  assign busy          = busy_q;
  assign load_err      = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_obf_key_loader.sv
// -----------------------------------------------------------------------------
// tb_obf_key_loader
// Directed bench for obf_key_loader. Two instances share the stimulus: dut
// (LOCK_AFTER_LOAD=0) and dut_lk (LOCK_AFTER_LOAD=1). dut_lk commits the first
// key and must refuse every later frame.
// -----------------------------------------------------------------------------
module tb_obf_key_loader;
  import obf_pkg::*;

  localparam int KW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          load_start;
  logic          key_bit;
  logic          key_bit_valid;

  logic          key_bit_ready;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          load_err;
  state_e        dbg_state;

  logic          lk_ready;
  logic [KW-1:0] lk_key_out;
  logic          lk_key_valid;
  logic          lk_busy;
  logic          lk_err;
  state_e        lk_state;

  obf_key_loader #(.N_CELLS(5), .LOCK_AFTER_LOAD(1'b0)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .key_bit       (key_bit),
    .key_bit_valid (key_bit_valid),
    .key_bit_ready (key_bit_ready),
    .key_out       (key_out),
    .key_valid     (key_valid),
    .busy          (busy),
    .load_err      (load_err),
    .dbg_state_o   (dbg_state)
  );

  obf_key_loader #(.N_CELLS(5), .LOCK_AFTER_LOAD(1'b1)) dut_lk (
    .clk           (clk),
    .rst           (rst),
    .load_start    (load_start),
    .key_bit       (key_bit),
    .key_bit_valid (key_bit_valid),
    .key_bit_ready (lk_ready),
    .key_out       (lk_key_out),
    .key_valid     (lk_key_valid),
    .busy          (lk_busy),
    .load_err      (lk_err),
    .dbg_state_o   (lk_state)
  );

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Offer one bit until it transfers; with rnd, valid is randomised per cycle.
  task automatic send_bit(input logic b, input bit rnd);
    bit   done;
    int   n;
    logic v;
    logic r;
    done    = 1'b0;
    n       = 0;
    key_bit = b;
    while (!done && n < 200) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      key_bit_valid = v;
      r = key_bit_ready;
      tick();
      if (v && r) begin
        done = 1'b1;
        xfer_cnt++;
      end
      n++;
    end
    key_bit_valid = 1'b0;
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [KW-1:0] k, input logic p, input bit rnd);
    for (int i = 0; i < KW; i++) send_bit(k[i], rnd);
    send_bit(p, rnd);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    load_start    = 1'b0;
    key_bit       = 1'b0;
    key_bit_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_key_out",   32'(key_out),       32'h000);
    chk("rst_key_valid", 32'(key_valid),     32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_err",       32'(load_err),      32'd0);
    chk("rst_ready",     32'(key_bit_ready), 32'd0);
    chk("rst_state",     32'(dbg_state),     32'(IDLE));

    // Clean load 10'h018, parity 0
    start();
    chk("start_busy",  32'(busy),          32'd1);
    chk("start_ready", 32'(key_bit_ready), 32'd1);
    chk("start_state", 32'(dbg_state),     32'(SHIFT));
    send_frame(10'h018, 1'b0, 1'b0);
    chk("chk_state",    32'(dbg_state),     32'(CHECK));
    chk("chk_ready",    32'(key_bit_ready), 32'd0);
    chk("chk_key_hold", 32'(key_out),       32'h000);
    tick();
    chk("commit_state",    32'(dbg_state), 32'(COMMIT));
    chk("commit_key_hold", 32'(key_out),   32'h000);
    tick();
    chk("clean_key_out",   32'(key_out),    32'h018);
    chk("clean_key_valid", 32'(key_valid),  32'd1);
    chk("clean_err",       32'(load_err),   32'd0);
    chk("clean_busy",      32'(busy),       32'd0);
    chk("lk_first_key",    32'(lk_key_out), 32'h018);

    // Lock: dut_lk refuses the next frame, dut accepts it
    start();
    chk("lk_busy",    32'(lk_busy),    32'd0);
    chk("lk_err",     32'(lk_err),     32'd1);
    chk("lk_key_out", 32'(lk_key_out), 32'h018);
    chk("lk_ready",   32'(lk_ready),   32'd0);
    chk("bad_busy",   32'(busy),       32'd1);

    // Bad parity on the same key
    send_frame(10'h018, 1'b1, 1'b0);
    tick();
    chk("bad_err",       32'(load_err),  32'd1);
    chk("bad_state",     32'(dbg_state), 32'(IDLE));
    chk("bad_busy_end",  32'(busy),      32'd0);
    tick();
    chk("bad_key_out",   32'(key_out),   32'h018);
    chk("bad_key_valid", 32'(key_valid), 32'd1);

    // Stalled frame 10'h3FF with random valid; load_start clears load_err
    start();
    chk("stall_err_clr", 32'(load_err), 32'd0);
    xfer_cnt = 0;
    send_frame(10'h3FF, 1'b0, 1'b1);
    chk("stall_xfers", 32'(xfer_cnt),      32'd11);
    chk("stall_ready", 32'(key_bit_ready), 32'd0);
    repeat (2) tick();
    chk("stall_key_out", 32'(key_out),  32'h3FF);
    chk("stall_err",     32'(load_err), 32'd0);

    // Abort after 4 bits (with a dropped bit on the abort cycle), then 10'h155
    start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    key_bit       = 1'b1;
    key_bit_valid = 1'b1;
    load_start    = 1'b1;
    tick();
    load_start    = 1'b0;
    key_bit_valid = 1'b0;
    chk("abort_state",    32'(dbg_state), 32'(SHIFT));
    chk("abort_key_hold", 32'(key_out),   32'h3FF);
    chk("abort_valid",    32'(key_valid), 32'd1);
    send_frame(10'h155, 1'b1, 1'b0);
    tick();
    chk("abort_key_hold2", 32'(key_out), 32'h3FF);
    tick();
    chk("abort_key_out",   32'(key_out),    32'h155);
    chk("lk_key_final",    32'(lk_key_out), 32'h018);

    // Asynchronous reset in the middle of a frame
    start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_key_out",   32'(key_out),       32'h000);
    chk("arst_key_valid", 32'(key_valid),     32'd0);
    chk("arst_busy",      32'(busy),          32'd0);
    chk("arst_err",       32'(load_err),      32'd0);
    chk("arst_ready",     32'(key_bit_ready), 32'd0);
    chk("arst_lk_err",    32'(lk_err),        32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_state", 32'(dbg_state), 32'(IDLE));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
